// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op codes, FSM states and operand decode helpers for muldiv_unit
package muldiv_pkg;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

    function automatic logic is_div(input logic [2:0] op);
        return op[2];
    endfunction

    function automatic logic is_signed_a(input logic [2:0] op);
        return !(op == OP_MULHU || op == OP_DIVU || op == OP_REMU);
    endfunction

    function automatic logic is_signed_b(input logic [2:0] op);
        return !(op == OP_MULHSU || op == OP_MULHU || op == OP_DIVU || op == OP_REMU);
    endfunction

endpackage

// File: rtl/muldiv_sign_adj.sv
// muldiv_sign_adj: conditional two's-complement negation of a value
module muldiv_sign_adj #(
    parameter int DATA_W = 64
) (
    input  logic [DATA_W-1:0] value,
    input  logic              negate,
    output logic [DATA_W-1:0] adjusted
);

    assign adjusted = negate ? -value : value;

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV64M multiply/divide engine with start/busy/done handshake
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int UNROLL = 1
) (
    input  logic              clk,
    input  logic              arst,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] operand_a,
    input  logic [DATA_W-1:0] operand_b,
    input  logic              flush,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result
);

    localparam int N  = DATA_W / UNROLL;
    localparam int CW = $clog2(N) + 1;
    localparam logic [DATA_W-1:0] MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};

    state_t              state, state_nxt;
    logic [2:0]          op_q;
    logic                sign_a, sign_b, fast;
    logic [DATA_W-1:0]   mag_a, mag_b, acc_hi, acc_lo;
    logic [CW-1:0]       cnt;
    logic                in_sa, in_sb, in_div0, in_ovf, in_fast;
    logic [DATA_W-1:0]   in_mag_a, in_mag_b, fast_val;
    logic                accept, fin_ok;
    logic [DATA_W-1:0]   step_hi, step_lo;
    logic [DATA_W:0]     sum, diff;
    logic                ge;
    logic [2*DATA_W-1:0] prod;
    logic [DATA_W-1:0]   quo, rem, res_nxt;

    assign in_sa    = is_signed_a(op) & operand_a[DATA_W-1];
    assign in_sb    = is_signed_b(op) & operand_b[DATA_W-1];
    assign in_div0  = is_div(op) && operand_b == '0;
    assign in_ovf   = (op == OP_DIV || op == OP_REM) && operand_a == MIN_NEG && operand_b == '1;
    assign in_fast  = in_div0 | in_ovf;
    // fast-path answers are fully known at capture, so they ride in acc_lo to FIN
    assign fast_val = in_div0 ? (op[1] ? operand_a : '1) : (op[1] ? '0 : operand_a);

    muldiv_sign_adj #(.DATA_W(DATA_W)) u_abs_a (.value(operand_a), .negate(in_sa), .adjusted(in_mag_a));
    muldiv_sign_adj #(.DATA_W(DATA_W)) u_abs_b (.value(operand_b), .negate(in_sb), .adjusted(in_mag_b));

    // UNROLL shift-add (multiply) or restoring-subtract (divide) steps on {acc_hi, acc_lo}
    always_comb begin
        step_hi = acc_hi;
        step_lo = acc_lo;
        sum     = '0;
        diff    = '0;
        ge      = 1'b0;
        for (int i = 0; i < UNROLL; i++) begin
            if (is_div(op_q)) begin
                diff    = {step_hi, step_lo[DATA_W-1]};
                ge      = diff >= {1'b0, mag_b};
                diff    = ge ? diff - {1'b0, mag_b} : diff;
                step_hi = diff[DATA_W-1:0];
                step_lo = {step_lo[DATA_W-2:0], ge};
            end else begin
                sum     = {1'b0, step_hi} + (step_lo[0] ? {1'b0, mag_a} : '0);
                step_hi = sum[DATA_W:1];
                step_lo = {sum[0], step_lo[DATA_W-1:1]};
            end
        end
    end

    muldiv_sign_adj #(.DATA_W(2*DATA_W)) u_prod (.value({acc_hi, acc_lo}), .negate(sign_a ^ sign_b), .adjusted(prod));
    muldiv_sign_adj #(.DATA_W(DATA_W))   u_quo  (.value(acc_lo), .negate(sign_a ^ sign_b), .adjusted(quo));
    muldiv_sign_adj #(.DATA_W(DATA_W))   u_rem  (.value(acc_hi), .negate(sign_a), .adjusted(rem));

    assign res_nxt = fast ? acc_lo :
                     is_div(op_q) ? (op_q[1] ? rem : quo) :
                     (op_q == OP_MUL ? prod[DATA_W-1:0] : prod[2*DATA_W-1:DATA_W]);

    // next-state decode; flush always wins and suppresses the done pulse
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        fin_ok    = 1'b0;
        case (state)
            IDLE: begin
                accept    = start && !flush;
                state_nxt = !accept ? IDLE : (in_fast ? FIN : CALC);
            end
            CALC: state_nxt = flush ? IDLE : (cnt == CW'(N - 1) ? FIN : CALC);
            FIN: begin
                fin_ok    = !flush;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk or posedge arst) begin
        if (arst) state <= IDLE;
        else      state <= state_nxt;
    end

    // operand capture on accept, one iteration per CALC cycle
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            op_q   <= '0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            fast   <= 1'b0;
            mag_a  <= '0;
            mag_b  <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            cnt    <= '0;
        end else if (accept) begin
            op_q   <= op;
            sign_a <= in_sa;
            sign_b <= in_sb;
            fast   <= in_fast;
            mag_a  <= in_mag_a;
            mag_b  <= in_mag_b;
            acc_hi <= '0;
            acc_lo <= in_fast ? fast_val : (is_div(op) ? in_mag_a : in_mag_b);
            cnt    <= '0;
        end else if (state == CALC) begin
            acc_hi <= step_hi;
            acc_lo <= step_lo;
            cnt    <= cnt + CW'(1);
        end
    end

    // registered outputs; busy stays up through the done cycle
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
        end else begin
            busy <= state_nxt != IDLE || fin_ok;
            done <= fin_ok;
            if (fin_ok) result <= res_nxt;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors against UNROLL = 1, 2 and 4 instances in parallel
module tb_muldiv_unit;
    import muldiv_pkg::*;

    typedef struct {
        logic [2:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
        bit          fast;
    } vec_t;

    localparam logic [63:0] MINV = 64'h8000_0000_0000_0000;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        arst = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  op = '0;
    logic [63:0] a = '0;
    logic [63:0] b = '0;
    logic        busy_v [3];
    logic        done_v [3];
    logic [63:0] result_v [3];
    int          tests = 0;
    int          fails = 0;
    vec_t        vecs [18];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        muldiv_unit #(.DATA_W(64), .UNROLL(1 << g)) dut (
            .clk(clk), .arst(arst), .start(start), .op(op),
            .operand_a(a), .operand_b(b), .flush(flush),
            .busy(busy_v[g]), .done(done_v[g]), .result(result_v[g])
        );
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // issue one op (called #1 after a rising edge), watch 70 edges, then check all instances
    task automatic run(input string name, input logic [2:0] vop, input logic [63:0] va, input logic [63:0] vb,
                       input logic [63:0] exp, input bit fast, input int stray_at, input int flush_at);
        int          lat [3];
        int          nd [3];
        logic [63:0] res [3];
        for (int i = 0; i < 3; i++) begin
            lat[i] = -1;
            nd[i]  = 0;
            res[i] = '0;
        end
        op = vop;
        a = va;
        b = vb;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        op = 3'($urandom);
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        for (int i = 0; i < 3; i++) check($sformatf("%s u%0d busy_after_start", name, 1 << i), 64'(busy_v[i]), 64'd1);
        for (int k = 1; k <= 70; k++) begin
            if (k == stray_at) begin
                start = 1'b1;
                op = OP_DIVU;
                a = 64'd100;
                b = 64'd7;
            end
            if (k == flush_at) flush = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            flush = 1'b0;
            if (k == flush_at)
                for (int i = 0; i < 3; i++) check($sformatf("%s u%0d busy_after_flush", name, 1 << i), 64'(busy_v[i]), 64'd0);
            for (int i = 0; i < 3; i++) begin
                if (done_v[i]) begin
                    nd[i]++;
                    if (lat[i] < 0) begin
                        lat[i] = k;
                        res[i] = result_v[i];
                    end
                end
            end
        end
        for (int i = 0; i < 3; i++) begin
            if (flush_at > 0) begin
                check($sformatf("%s u%0d done_count", name, 1 << i), 64'(nd[i]), 64'd0);
                check($sformatf("%s u%0d result_kept", name, 1 << i), result_v[i], exp);
            end else begin
                check($sformatf("%s u%0d result", name, 1 << i), res[i], exp);
                check($sformatf("%s u%0d latency", name, 1 << i), 64'(lat[i]), fast ? 64'd1 : 64'(64 / (1 << i) + 1));
                check($sformatf("%s u%0d done_count", name, 1 << i), 64'(nd[i]), 64'd1);
            end
        end
    endtask

    initial begin
        vecs[0]  = '{OP_MUL,    64'd7,   -64'sd3, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0};
        vecs[1]  = '{OP_MULHU,  ONES,    ONES,    64'hFFFF_FFFF_FFFF_FFFE, 1'b0};
        vecs[2]  = '{OP_MULH,   ONES,    ONES,    64'd0,                   1'b0};
        vecs[3]  = '{OP_MULHSU, ONES,    64'd2,   ONES,                    1'b0};
        vecs[4]  = '{OP_MULH,   MINV,    MINV,    64'h4000_0000_0000_0000, 1'b0};
        vecs[5]  = '{OP_MUL,    64'h1_0000_0001, 64'h1_0000_0001, 64'h0000_0002_0000_0001, 1'b0};
        vecs[6]  = '{OP_DIV,    -64'sd7, 64'd2,   64'hFFFF_FFFF_FFFF_FFFD, 1'b0};
        vecs[7]  = '{OP_REM,    -64'sd7, 64'd2,   ONES,                    1'b0};
        vecs[8]  = '{OP_DIVU,   64'd100, 64'd7,   64'd14,                  1'b0};
        vecs[9]  = '{OP_REMU,   64'd100, 64'd7,   64'd2,                   1'b0};
        vecs[10] = '{OP_DIV,    64'd7,   -64'sd2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0};
        vecs[11] = '{OP_REM,    64'd7,   -64'sd2, 64'd1,                   1'b0};
        vecs[12] = '{OP_DIVU,   MINV,    64'd3,   64'h2AAA_AAAA_AAAA_AAAA, 1'b0};
        vecs[13] = '{OP_REMU,   MINV,    64'd3,   64'd2,                   1'b0};
        vecs[14] = '{OP_DIVU,   64'd5,   64'd0,   ONES,                    1'b1};
        vecs[15] = '{OP_REM,    64'd5,   64'd0,   64'd5,                   1'b1};
        vecs[16] = '{OP_DIV,    MINV,    ONES,    MINV,                    1'b1};
        vecs[17] = '{OP_REM,    MINV,    ONES,    64'd0,                   1'b1};

        #1 arst = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("reset u%0d busy", 1 << i), 64'(busy_v[i]), 64'd0);
            check($sformatf("reset u%0d done", 1 << i), 64'(done_v[i]), 64'd0);
            check($sformatf("reset u%0d result", 1 << i), result_v[i], 64'd0);
        end
        #10 arst = 1'b0;
        @(posedge clk);
        #1;

        for (int v = 0; v < 18; v++)
            run($sformatf("vec%0d", v), vecs[v].op, vecs[v].a, vecs[v].b, vecs[v].exp, vecs[v].fast, 0, 0);

        run("mul3x5", OP_MUL, 64'd3, 64'd5, 64'd15, 1'b0, 0, 0);
        run("div_flush", OP_DIV, 64'd100, 64'd7, 64'd15, 1'b0, 0, 10);
        run("mul_stray", OP_MUL, 64'd3, 64'd4, 64'd12, 1'b0, 5, 0);

        op = OP_DIV;
        a = 64'd1000;
        b = 64'd3;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) check($sformatf("pre_arst u%0d busy", 1 << i), 64'(busy_v[i]), 64'd1);
        arst = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("arst u%0d busy", 1 << i), 64'(busy_v[i]), 64'd0);
            check($sformatf("arst u%0d done", 1 << i), 64'(done_v[i]), 64'd0);
            check($sformatf("arst u%0d result", 1 << i), result_v[i], 64'd0);
        end
        #2 arst = 1'b0;
        @(posedge clk);
        #1;
        run("mul6x7", OP_MUL, 64'd6, 64'd7, 64'd42, 1'b0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
